// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and data-memory bus bundle for mem_access_unit
//
// Purpose: groups the pipeline request/response handshake and the data-memory
// port of mem_access_unit into one interface.
// Ports (signals):
//   req_valid/req_ready/req_we/req_word/req_signed/req_addr/req_wdata - request
//   rsp_valid/rsp_data                                                - response pulse
//   busy                                                              - sequencer not idle
//   mem_addr/mem_in/mem_mov_sz/mem_write_en/mem_out                   - data memory port
// Modports: slave = the unit itself, master = the pipeline/memory side.

interface mem_access_unit_if #(
  parameter int ADDR_LEN = 16
);
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic                req_word;
  logic                req_signed;
  logic [ADDR_LEN-1:0] req_addr;
  logic [15:0]         req_wdata;
  logic                rsp_valid;
  logic [15:0]         rsp_data;
  logic                busy;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [15:0]         mem_in;
  logic                mem_mov_sz;
  logic                mem_write_en;
  logic [15:0]         mem_out;

  modport slave (
    input  req_valid, req_we, req_word, req_signed, req_addr, req_wdata, mem_out,
    output req_ready, rsp_valid, rsp_data, busy, mem_addr, mem_in, mem_mov_sz, mem_write_en
  );

  modport master (
    output req_valid, req_we, req_word, req_signed, req_addr, req_wdata, mem_out,
    input  req_ready, rsp_valid, rsp_data, busy, mem_addr, mem_in, mem_mov_sz, mem_write_en
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer between execute stage and byte-addressed data memory
//
// Purpose: accepts one request at a time; stores are a single write cycle
// (16-bit stores use the memory's word-write option), loads are sequential
// byte reads against a one-cycle registered read port, assembled
// little-endian and sign/zero-extended for byte loads.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset
//   bus - mem_access_unit_if.slave (request, response, memory port, busy)

module mem_access_unit #(
  parameter int ADDR_LEN = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_access_unit_if.slave    bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_HI    = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [ADDR_LEN-1:0] addr_q;
  logic [15:0]         wdata_q;
  logic [7:0]          lo_q;
  logic [7:0]          hi_q;
  logic [15:0]         rsp_data_q;
  logic                word_q;
  logic                we_q;
  logic                signed_q;
  logic [15:0]         rsp_value;
  logic                accept;
  logic                unused_mem_hi;

  // Only the low byte of the memory read port carries data.
  assign unused_mem_hi = ^bus.mem_out[15:8];

  assign accept = (state_q == S_IDLE) && bus.req_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.req_valid) state_d = bus.req_we ? S_WRITE : S_ISSUE;
      S_WRITE: state_d = S_RESP;
      S_ISSUE: state_d = S_LO;
      S_LO:    state_d = word_q ? S_HI : S_RESP;
      S_HI:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_value = 16'h0000;
    if (!we_q) begin
      if (word_q)        rsp_value = {hi_q, lo_q};
      else if (signed_q) rsp_value = {{8{lo_q[7]}}, lo_q};
      else               rsp_value = {8'h00, lo_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= 16'h0000;
      lo_q       <= 8'h00;
      hi_q       <= 8'h00;
      rsp_data_q <= 16'h0000;
      word_q     <= 1'b0;
      we_q       <= 1'b0;
      signed_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        we_q     <= bus.req_we;
        word_q   <= bus.req_word;
        signed_q <= bus.req_signed;
      end
      // The byte read issued in the previous cycle is on mem_out now.
      if (state_q == S_LO) lo_q <= bus.mem_out[7:0];
      if (state_q == S_HI) hi_q <= bus.mem_out[7:0];
      // Latch the result so rsp_data holds after the pulse.
      if (state_q == S_RESP) rsp_data_q <= rsp_value;
    end
  end

  assign bus.req_ready    = !rst && (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.rsp_valid    = (state_q == S_RESP);
  // During RESP the result comes straight from lo/hi so the pulse cycle
  // already carries the new value; afterwards the latched copy holds it.
  assign bus.rsp_data     = (state_q == S_RESP) ? rsp_value : rsp_data_q;
  assign bus.mem_write_en = !rst && (state_q == S_WRITE);
  assign bus.mem_mov_sz   = (state_q == S_WRITE) && word_q;
  assign bus.mem_in       = wdata_q;
  // LO presents the high-byte address so its read overlaps lo capture.
  assign bus.mem_addr     = ((state_q == S_LO) || (state_q == S_HI)) ? (addr_q + ADDR_LEN'(1)) : addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;
  localparam int AL = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_LEN(AL)) bus ();
  mem_access_unit #(.ADDR_LEN(AL)) dut (.clk(clk), .rst(rst), .bus(bus));

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int last_acc = 0;

  always @(posedge clk) cyc++;

  // Byte-addressed data memory: registered read, word write puts in[15:8] at addr+1.
  logic [7:0]    mem [0:4095];
  logic [AL-1:0] mem_a1;
  always @(posedge clk) begin
    mem_a1 = bus.mem_addr + 12'd1;
    if (bus.mem_write_en) begin
      mem[bus.mem_addr] <= bus.mem_in[7:0];
      if (bus.mem_mov_sz) mem[mem_a1] <= bus.mem_in[15:8];
    end
    bus.mem_out <= {~mem[bus.mem_addr], mem[bus.mem_addr]};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a request accepted in cycle a answers in cycle a+L
  // (L = 2 store, 3 byte load, 4 word load), is busy a+1..a+L, writes in a+1.
  logic [7:0]    ref_mem [0:4095];
  bit            pend = 0;
  int            acc_c, lat;
  bit            p_we, p_word, p_signed;
  logic [AL-1:0] p_addr, p_a1;
  logic [15:0]   p_wdata;
  logic [15:0]   e_rd = 16'h0000;
  bit            m_busy, e_valid, e_we;

  always @(negedge clk) begin
    m_busy  = pend && (cyc >= acc_c + 1) && (cyc <= acc_c + lat);
    e_valid = pend && (cyc == acc_c + lat);
    e_we    = !rst && pend && p_we && (cyc == acc_c + 1);
    if (e_valid) begin
      p_a1 = p_addr + 12'd1;
      if (p_we)          e_rd = 16'h0000;
      else if (p_word)   e_rd = {ref_mem[p_a1], ref_mem[p_addr]};
      else if (p_signed) e_rd = {{8{ref_mem[p_addr][7]}}, ref_mem[p_addr]};
      else               e_rd = {8'h00, ref_mem[p_addr]};
    end
    chk("req_ready", {31'b0, bus.req_ready}, {31'b0, !rst && !m_busy});
    chk("busy", {31'b0, bus.busy}, {31'b0, m_busy});
    chk("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, e_valid});
    chk("rsp_data", {16'b0, bus.rsp_data}, {16'b0, e_rd});
    chk("mem_write_en", {31'b0, bus.mem_write_en}, {31'b0, e_we});
    if (e_we) begin
      chk("wr_addr", {20'b0, bus.mem_addr}, {20'b0, p_addr});
      chk("wr_mov_sz", {31'b0, bus.mem_mov_sz}, {31'b0, p_word});
      chk("wr_data_lo", {24'b0, bus.mem_in[7:0]}, {24'b0, p_wdata[7:0]});
      p_a1 = p_addr + 12'd1;
      ref_mem[p_addr] = p_wdata[7:0];
      if (p_word) ref_mem[p_a1] = p_wdata[15:8];
    end
    if (e_valid) pend = 0;
    if (rst) begin
      pend = 0;
      e_rd = 16'h0000;
    end else if (bus.req_valid && !m_busy) begin
      pend = 1; acc_c = cyc;
      p_we = bus.req_we; p_word = bus.req_word; p_signed = bus.req_signed;
      p_addr = bus.req_addr; p_wdata = bus.req_wdata;
      lat = bus.req_we ? 2 : (bus.req_word ? 4 : 3);
    end
  end

  task automatic issue(input bit we, input bit word, input bit sgn, input logic [AL-1:0] a,
                       input logic [15:0] d, output int waits);
    int n = 0;
    bus.req_we = we; bus.req_word = word; bus.req_signed = sgn;
    bus.req_addr = a; bus.req_wdata = d; bus.req_valid = 1'b1;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("issue_timeout", 32'd0, 32'd1);
    waits = n;
    last_acc = cyc;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string nm, input int exp_lat, input logic [15:0] exp_d);
    int n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid) chk({nm, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({nm, "_latency"}, cyc - last_acc, exp_lat);
      chk({nm, "_data"}, {16'b0, bus.rsp_data}, {16'b0, exp_d});
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_quiet(input string nm, input int ncyc);
    int pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) pulses++;
    end
    chk({nm, "_no_rsp"}, pulses, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, a1;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_word = 1'b0;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = 16'h0000;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("reset_busy", {31'b0, bus.busy}, 32'd0);
    chk("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("reset_rsp_data", {16'b0, bus.rsp_data}, 32'd0);
    @(posedge clk); #1;

    // Word store then word load.
    issue(1, 1, 0, 12'h010, 16'hBEEF, w);
    wait_rsp("wstore", 2, 16'h0000);
    issue(0, 1, 0, 12'h010, 16'h0000, w);
    wait_rsp("wload", 4, 16'hBEEF);

    // Byte store 0x80, signed and unsigned byte loads.
    issue(1, 0, 0, 12'h020, 16'hAA80, w);
    wait_rsp("bstore", 2, 16'h0000);
    issue(0, 0, 1, 12'h020, 16'h0000, w);
    wait_rsp("bload_s", 3, 16'hFF80);
    issue(0, 0, 0, 12'h020, 16'h0000, w);
    wait_rsp("bload_u", 3, 16'h0080);

    // Byte assembly order across the address wrap.
    issue(1, 0, 0, 12'hFFF, 16'h0034, w);
    wait_rsp("bstore_fff", 2, 16'h0000);
    issue(1, 0, 0, 12'h000, 16'h0012, w);
    wait_rsp("bstore_000", 2, 16'h0000);
    issue(0, 1, 0, 12'hFFF, 16'h0000, w);
    wait_rsp("wload_wrap", 4, 16'h1234);

    // req_valid held across a byte load: next accept only back in IDLE.
    issue(0, 0, 0, 12'h020, 16'h0000, w);
    a1 = last_acc;
    issue(1, 0, 0, 12'h040, 16'h0077, w);
    chk("b2b_ready_low_cycles", w, 3);
    chk("b2b_accept_spacing", last_acc - a1, 4);
    wait_rsp("b2b_store", 2, 16'h0000);

    // Reset in the WRITE cycle suppresses the write.
    issue(1, 0, 0, 12'h030, 16'h0055, w);
    wait_rsp("bstore_55", 2, 16'h0000);
    issue(1, 0, 0, 12'h030, 16'h00AA, w);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_write_en", {31'b0, bus.mem_write_en}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    expect_quiet("rst_write", 6);
    issue(0, 0, 0, 12'h030, 16'h0000, w);
    wait_rsp("bload_after_rst", 3, 16'h0055);

    // Reset in the HI cycle of a word load.
    issue(0, 1, 0, 12'h010, 16'h0000, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hi_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_hi_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_hi_rsp_data", {16'b0, bus.rsp_data}, 32'd0);
    @(posedge clk); #1;
    expect_quiet("rst_hi", 6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
